// File: rtl/keypad_entry_reader.sv
// keypad_entry_reader
//   Consumes the keypad scanner's 4-bit key code. Each code must be stable for
//   STABLE_CYCLES samples before it is acknowledged, and STABLE_CYCLES no-key
//   samples must follow before another key is accepted. Digits build a BCD entry
//   buffer ('*' = backspace, '#' = submit); a submit converts the buffer to binary
//   and offers it over a valid/ready handshake.
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   key_code     in   0-9 digit, 10 '*', 11 '#', 12-15 no key
//   ack_key      out  one-cycle pulse when a key is accepted
//   bcd_digits   out  entry buffer, newest digit in nibble 0
//   digit_count  out  number of digits held
//   value        out  binary result of the last submit
//   value_valid  out  value offered to the consumer
//   value_ready  in   consumer accepts value
module keypad_entry_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_DIGITS    = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              key_code,
    output logic                    ack_key,
    output logic [4*MAX_DIGITS-1:0] bcd_digits,
    output logic [3:0]              digit_count,
    output logic [31:0]             value,
    output logic                    value_valid,
    input  logic                    value_ready
);

    localparam int unsigned BW = 4 * MAX_DIGITS;

    typedef logic [BW-1:0] bcd_t;

    typedef enum logic [2:0] {
        StIdle,
        StStable,
        StAck,
        StConvert,
        StValid,
        StRelease
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  code_q, code_d;
    // Shared counter: stability samples, conversion index, release samples.
    logic [7:0]  cnt_q, cnt_d;
    bcd_t        bcd_q, bcd_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] value_q, value_d;
    logic        ack_q, valid_q;

    logic        key_valid;
    logic [8:0]  cnt_inc;
    logic        stable_done;
    bcd_t        conv_sh;
    logic [3:0]  nib;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        count_d = count_q;
        value_d = value_q;

        key_valid   = (key_code <= 4'd11);
        cnt_inc     = {1'b0, cnt_q} + 9'd1;
        stable_done = (cnt_inc == 9'(STABLE_CYCLES));
        // Most significant nibble first; cnt_q is the conversion step here.
        conv_sh     = bcd_q >> (4 * (MAX_DIGITS - 1 - 32'(cnt_q)));
        nib         = conv_sh[3:0];

        unique case (state_q)
            StIdle: begin
                if (key_valid) begin
                    code_d  = key_code;
                    cnt_d   = 8'd1;
                    state_d = StStable;
                end
            end
            StStable: begin
                if (key_code != code_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc[7:0];
                    if (stable_done) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                state_d = StRelease;
                cnt_d   = 8'd0;
                if (code_q <= 4'd9) begin
                    if (count_q < 4'(MAX_DIGITS)) begin
                        bcd_d   = (bcd_q << 4) | bcd_t'(code_q);
                        count_d = count_q + 4'd1;
                    end
                end else if (code_q == 4'd10) begin
                    if (count_q != 4'd0) begin
                        bcd_d   = bcd_q >> 4;
                        count_d = count_q - 4'd1;
                    end
                end else if (count_q != 4'd0) begin
                    state_d = StConvert;
                    value_d = 32'd0;
                end
            end
            StConvert: begin
                // value*10 + digit, with the multiply as two shifts.
                value_d = (value_q << 3) + (value_q << 1) + 32'(nib);
                cnt_d   = cnt_inc[7:0];
                if (cnt_inc == 9'(MAX_DIGITS)) begin
                    state_d = StValid;
                    cnt_d   = 8'd0;
                end
            end
            StValid: begin
                if (value_ready) begin
                    bcd_d   = '0;
                    count_d = 4'd0;
                    cnt_d   = 8'd0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (key_valid) begin
                    cnt_d = 8'd0;
                end else begin
                    cnt_d = cnt_inc[7:0];
                    if (stable_done) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            code_q  <= 4'd0;
            cnt_q   <= 8'd0;
            bcd_q   <= '0;
            count_q <= 4'd0;
            value_q <= 32'd0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            count_q <= count_d;
            value_q <= value_d;
            // Registered from the next state so the flags align with the state.
            ack_q   <= (state_d == StAck);
            valid_q <= (state_d == StValid);
        end
    end

    assign ack_key     = ack_q;
    assign bcd_digits  = bcd_q;
    assign digit_count = count_q;
    assign value       = value_q;
    assign value_valid = valid_q;

endmodule

// File: tb/tb_keypad_entry_reader.sv
module tb_keypad_entry_reader;

    localparam int unsigned STABLE = 4;
    localparam int unsigned MAXD   = 6;

    logic        clock;
    logic        reset;
    logic [3:0]  key_code;
    logic        ack_key;
    logic [23:0] bcd_digits;
    logic [3:0]  digit_count;
    logic [31:0] value;
    logic        value_valid;
    logic        value_ready;

    keypad_entry_reader #(
        .STABLE_CYCLES(STABLE),
        .MAX_DIGITS   (MAXD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_code   (key_code),
        .ack_key    (ack_key),
        .bcd_digits (bcd_digits),
        .digit_count(digit_count),
        .value      (value),
        .value_valid(value_valid),
        .value_ready(value_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int acks     = 0;
    int hs       = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] keys;  // key j in nibble j
        int          n;
        bit          submit;
        logic [31:0] exp_value;
        logic [23:0] exp_bcd;
        logic [3:0]  exp_cnt;
    } rec_t;

    rec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int gap);
        key_code = k;
        repeat (hold) tick();
        key_code = 4'hF;
        repeat (gap) tick();
    endtask

    // Scoreboard: every handshake must match the oldest expected value.
    always @(negedge clock) begin
        if (!reset) begin
            if (ack_key) acks++;
            if (value_valid && value_ready) begin
                hs++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_value: got %0d expected no transfer", value);
                end else begin
                    check("value", value, exp_q.pop_front());
                end
            end
        end
    end

    task automatic run_record(input int i);
        int a0;
        int h0;
        logic [3:0] k;
        a0 = acks;
        h0 = hs;
        for (int j = 0; j < tbl[i].n; j++) begin
            k = tbl[i].keys[4*j +: 4];
            if (k == 4'd11 && tbl[i].submit) exp_q.push_back(tbl[i].exp_value);
            press(k, 6, 6);
        end
        repeat (20) tick();
        check($sformatf("rec%0d_acks", i), 32'(acks - a0), 32'(tbl[i].n));
        check($sformatf("rec%0d_xfers", i), 32'(hs - h0), tbl[i].submit ? 32'd1 : 32'd0);
        check($sformatf("rec%0d_bcd", i), 32'(bcd_digits), 32'(tbl[i].exp_bcd));
        check($sformatf("rec%0d_count", i), 32'(digit_count), 32'(tbl[i].exp_cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(ack_key), 32'd0);
        check({tag, "_bcd"}, 32'(bcd_digits), 32'd0);
        check({tag, "_count"}, 32'(digit_count), 32'd0);
        check({tag, "_value"}, value, 32'd0);
        check({tag, "_valid"}, 32'(value_valid), 32'd0);
    endtask

    initial begin
        int a0;
        int lat;
        bit seen;

        tbl[0] = '{32'h0000_B321, 4, 1'b1, 32'd123,    24'h0,      4'd0};
        tbl[1] = '{32'h000B_9A74, 5, 1'b1, 32'd49,     24'h0,      4'd0};
        tbl[2] = '{32'h0000_000A, 1, 1'b0, 32'd0,      24'h0,      4'd0};
        tbl[3] = '{32'h0765_4321, 7, 1'b0, 32'd0,      24'h123456, 4'd6};
        tbl[4] = '{32'h0000_000B, 1, 1'b1, 32'd123456, 24'h0,      4'd0};
        tbl[5] = '{32'h0000_000B, 1, 1'b0, 32'd0,      24'h0,      4'd0};
        tbl[6] = '{32'h0000_00B9, 2, 1'b1, 32'd9,      24'h0,      4'd0};

        reset       = 1'b1;
        key_code    = 4'hF;
        value_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) tick();

        // Ack latency from the first valid sample, then buffer one cycle later.
        key_code = 4'd5;
        lat = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (ack_key) begin
                lat = t;
                break;
            end
        end
        check("ack_latency", 32'(lat), 32'(STABLE));
        tick();
        check("latency_bcd", 32'(bcd_digits), 32'h5);
        check("latency_ack_pulse", 32'(ack_key), 32'd0);
        key_code = 4'hF;
        repeat (10) tick();
        press(4'd10, 6, 10);
        check("latency_cleared", 32'(digit_count), 32'd0);

        for (int i = 0; i < 6; i++) run_record(i);

        // Bounce: short press, glitch, then a real press.
        a0 = acks;
        key_code = 4'd5; repeat (2) tick();
        key_code = 4'hF; tick();
        key_code = 4'd5; repeat (6) tick();
        key_code = 4'hF; repeat (10) tick();
        check("bounce_acks", 32'(acks - a0), 32'd1);
        check("bounce_bcd", 32'(bcd_digits), 32'h5);
        check("bounce_count", 32'(digit_count), 32'd1);
        press(4'd10, 6, 10);

        // Backpressure with key 3 held across conversion and valid.
        value_ready = 1'b0;
        press(4'd8, 6, 6);
        press(4'd8, 6, 6);
        key_code = 4'd11;
        repeat (6) tick();
        key_code = 4'd3;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (value_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        exp_q.push_back(32'd88);
        a0 = acks;
        for (int t = 0; t < 10; t++) begin
            tick();
            check("bp_valid_held", 32'(value_valid), 32'd1);
            check("bp_value_held", value, 32'd88);
        end
        check("bp_no_ack", 32'(acks - a0), 32'd0);
        value_ready = 1'b1;
        tick();
        check("bp_valid_drop", 32'(value_valid), 32'd0);
        check("bp_bcd_cleared", 32'(bcd_digits), 32'd0);
        check("bp_value_kept", value, 32'd88);
        repeat (10) tick();
        key_code = 4'hF;
        repeat (6) tick();
        check("bp_held_no_ack", 32'(acks - a0), 32'd0);
        press(4'd3, 6, 10);
        check("bp_fresh_ack", 32'(acks - a0), 32'd1);
        check("bp_fresh_count", 32'(digit_count), 32'd1);
        press(4'd10, 6, 10);

        // No auto-repeat on a long hold.
        a0 = acks;
        press(4'd8, 100, 10);
        check("hold_acks", 32'(acks - a0), 32'd1);
        check("hold_count", 32'(digit_count), 32'd1);
        press(4'd10, 6, 10);

        // Reset during conversion.
        press(4'd4, 6, 10);
        key_code = 4'd11;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset    = 1'b0;
        key_code = 4'hF;
        repeat (10) tick();
        run_record(6);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_entry_reader.md
Name: keypad_entry_reader

Overview:
- Processor-side consumer of the keypad scanner's 4-bit key code.
- Filters each code for stability, pulses a one-cycle acknowledge, and waits for key release before accepting the next key.
- Assembles decimal digits into a BCD entry buffer: '*' is backspace, '#' is submit.
- On submit, converts the buffer to a binary value and offers it to the ATM control logic over a valid/ready handshake.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required to accept a key, and consecutive no-key samples required to accept its release. Legal range 2..255.
- MAX_DIGITS, 6: entry buffer depth in decimal digits. Legal range 1..9, which guarantees the 32-bit result cannot overflow.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_code  in  4  scanner code: 0-9 digit, 10 '*', 11 '#', 13 scanner busy; 12, 13, 14 and 15 all mean no key
- ack_key  out  1  one-cycle pulse, key accepted
- bcd_digits  out  4*MAX_DIGITS  entry buffer; newest digit in nibble 0; unused nibbles are 0
- digit_count  out  4  number of digits held, 0..MAX_DIGITS
- value  out  32  binary result of the last submit
- value_valid  out  1  value available
- value_ready  in  1  consumer accepts value

Behaviour:
- Reset: every output is 0, all internal registers are cleared, state = IDLE. Reset wins over every other event, in every state.
- All outputs are registered.
- IDLE:
  - Valid code (0-11): capture it, sample count = 1, go to STABLE.
  - Otherwise stay in IDLE.
- STABLE:
  - Sample differs from the captured code (including any no-key code): go to IDLE, no ack.
  - Sample matches: increment the count. When the count reaches STABLE_CYCLES, go to ACK.
- ACK (exactly one cycle): ack_key = 1. The action below is visible on the next cycle.
  - Digit d, count < MAX_DIGITS: bcd_digits = (bcd_digits << 4) | d; digit_count + 1.
  - Digit d, count == MAX_DIGITS: digit ignored, ack still given.
  - '*', count > 0: bcd_digits >> 4; digit_count - 1.
  - '*', count == 0: no change.
  - '#', count > 0: go to CONVERT.
  - '#', count == 0: ignored, go to RELEASE.
  - All other cases: go to RELEASE.
- CONVERT (exactly MAX_DIGITS cycles):
  - value is cleared on entry.
  - Cycle k (k = 0..MAX_DIGITS-1): value = value*10 + nibble[MAX_DIGITS-1-k]. Leading-zero nibbles are harmless.
  - The multiply by 10 is implemented as (v<<3)+(v<<1).
  - Then go to VALID.
- VALID:
  - value_valid = 1; value holds steady.
  - On a cycle with value_valid & value_ready:
    - next cycle: value_valid = 0; bcd_digits and digit_count cleared; value retained;
    - go to RELEASE.
- RELEASE:
  - Count consecutive no-key samples. Any valid code resets the count to 0.
  - When the count reaches STABLE_CYCLES, go to IDLE.
- Key masking:
  - During CONVERT and VALID, key_code is ignored and ack_key is never asserted.
  - A key pressed during these states is acknowledged only after RELEASE completes, and only if it is present in IDLE.
- No auto-repeat: a key held indefinitely produces exactly one ack_key.
- Latency: first valid sample at cycle 0 → ack_key high at cycle STABLE_CYCLES → buffer updated at cycle STABLE_CYCLES+1.
- '#' to value_valid: STABLE_CYCLES + 1 + MAX_DIGITS cycles.

Test Plan:
- Basic entry (STABLE_CYCLES=4, MAX_DIGITS=6, value_ready=1): press 1,2,3,# for 6 cycles each, with 6 idle cycles (code 15) between presses → four ack_key pulses; value_valid=1 for one cycle with value=123; digit_count returns to 0.
- Bounce: code 5 for 2 cycles, 15 for 1 cycle, then 5 for 6 cycles, then release → exactly one ack_key; bcd_digits=0x000005; digit_count=1.
- Backspace: keys 4,7,*,9,# → value=49.
  - Separately, '*' with an empty buffer → ack_key pulses; digit_count stays 0.
- Limits: enter 7 digits 1..7 → seventh is acked but dropped; bcd_digits=0x123456; digit_count=6. Then '#' → value=123456.
  - Separately, '#' with an empty buffer → ack_key pulses; value_valid never rises.
- Backpressure and hold: submit 88 with value_ready=0 for 10 cycles while key 3 is held → value_valid stays 1; value=88; no ack_key.
  - Raise value_ready → value_valid drops; ack for key 3 occurs only after a full release and a fresh press.
  - Separately, hold key 8 for 100 cycles → exactly one ack_key.
- Reset mid-operation: assert reset during CONVERT → next cycle all outputs are 0. A subsequent entry of 9,# yields value=9.
